// File: rtl/ascon_pkg.sv
// Shared definitions for the ascon serial loader.
// Holds the host field-select codes, fixed field lengths, the loader FSM
// state type and a helper that sizes the common serial window.
package ascon_pkg;

    localparam logic [2:0] SEL_KEY   = 3'd0;
    localparam logic [2:0] SEL_NONCE = 3'd1;
    localparam logic [2:0] SEL_AD    = 3'd2;
    localparam logic [2:0] SEL_TEXT  = 3'd3;
    localparam logic [2:0] SEL_TAG   = 3'd4;

    localparam int unsigned TAG_LEN   = 128;
    localparam int unsigned NONCE_LEN = 128;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_START,
        ST_WAIT_DONE
    } state_t;

    // Serial window length: the longest of the streamed fields.
    function automatic int unsigned max_len(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c,
                                            input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/ascon_field_buf.sv
// One host-loaded field buffer.
// Words enter at the LSB end so the first word written ends up most
// significant. A word counter sets the full flag after LEN/W words; the
// bit-select output presents bit LEN-1-idx (0 once idx runs past LEN).
// Ports:
//   clk, rst   clock, synchronous active-low reset
//   clr        clear word counter and full flag
//   wr         write one word (ignored once full)
//   data       W-bit word
//   idx        serial bit index within the shared window
//   full       all LEN/W words received
//   bit_o      selected bit for the current idx
module ascon_field_buf
    import ascon_pkg::*;
#(
    parameter int unsigned LEN = 128,
    parameter int unsigned W   = 8,
    parameter int unsigned IW  = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          wr,
    input  logic [W-1:0]  data,
    input  logic [IW-1:0] idx,
    output logic          full,
    output logic          bit_o
);

    localparam int unsigned WORDS = LEN / W;
    localparam int unsigned CW    = $clog2(WORDS + 1);
    localparam int unsigned BW    = (LEN > 1) ? $clog2(LEN) : 1;

    logic [LEN-1:0] data_q;
    logic [CW-1:0]  cnt_q;
    logic           full_q;
    logic [BW-1:0]  pos;

    always_ff @(posedge clk) begin
        if (!rst) begin
            data_q <= '0;
            cnt_q  <= '0;
            full_q <= 1'b0;
        end else if (clr) begin
            cnt_q  <= '0;
            full_q <= 1'b0;
        end else if (wr && !full_q) begin
            data_q <= {data_q[LEN-W-1:0], data};
            cnt_q  <= cnt_q + CW'(1);
            if (cnt_q == CW'(WORDS - 1)) full_q <= 1'b1;
        end
    end

    always_comb begin
        pos   = '0;
        bit_o = 1'b0;
        if (32'(idx) < LEN) begin
            pos   = BW'(LEN - 1 - 32'(idx));
            bit_o = data_q[pos];
        end
    end

    assign full = full_q;

endmodule

// File: rtl/ascon_serial_loader.sv
// Upstream feeder for the ascon core.
// The host loads key, nonce, associated data, text and tag as W-bit words;
// on a go request the block streams every field MSB-first in one shared
// MAX-cycle window, holds the encryption or decryption start line high for
// START_CYC cycles, then waits for the core's done flag.
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   in_valid/in_ready        host word handshake
//   in_data, in_sel          word and field select (0 key .. 4 tag)
//   go_enc, go_dec           run requests
//   done_i                   core finished (encryption_r | decryption_r)
//   key_SO .. tag_SO         registered serial field bits
//   encryption_s_SO,
//   decryption_s_SO          registered core start lines
//   busy                     not IDLE
//   done, go_err, in_err     one-cycle status pulses
module ascon_serial_loader
    import ascon_pkg::*;
#(
    parameter int unsigned k         = 128,
    parameter int unsigned A_l       = 112,
    parameter int unsigned text_l    = 128,
    parameter int unsigned W         = 8,
    parameter int unsigned START_CYC = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic [2:0]   in_sel,
    input  logic         go_enc,
    input  logic         go_dec,
    input  logic         done_i,
    output logic         key_SO,
    output logic         nonce_SO,
    output logic         associated_SO,
    output logic         plaintext_SO,
    output logic         tag_SO,
    output logic         encryption_s_SO,
    output logic         decryption_s_SO,
    output logic         busy,
    output logic         done,
    output logic         go_err,
    output logic         in_err
);

    localparam int unsigned MAX = max_len(k, A_l, text_l, max_len(NONCE_LEN, TAG_LEN, 1, 1));
    localparam int unsigned IW  = (MAX > 1) ? $clog2(MAX) : 1;
    localparam int unsigned SW  = (START_CYC > 1) ? $clog2(START_CYC) : 1;

    state_t        state_q, state_d;
    logic [IW-1:0] i_q, i_d;
    logic [SW-1:0] sc_q, sc_d;
    logic          dec_q, dec_d;

    logic [4:0]    full;
    logic [4:0]    bits;
    logic [7:0]    full_ext;
    logic [4:0]    wr;
    logic          clr;

    logic key_d, nonce_d, ad_d, pt_d, tag_d, enc_s_d, dec_s_d;
    logic done_d, go_err_d, in_err_d;

    ascon_field_buf #(.LEN(k), .W(W), .IW(IW)) u_key (
        .clk(clk), .rst(rst), .clr(clr), .wr(wr[SEL_KEY]), .data(in_data),
        .idx(i_q), .full(full[SEL_KEY]), .bit_o(bits[SEL_KEY])
    );
    ascon_field_buf #(.LEN(NONCE_LEN), .W(W), .IW(IW)) u_nonce (
        .clk(clk), .rst(rst), .clr(clr), .wr(wr[SEL_NONCE]), .data(in_data),
        .idx(i_q), .full(full[SEL_NONCE]), .bit_o(bits[SEL_NONCE])
    );
    ascon_field_buf #(.LEN(A_l), .W(W), .IW(IW)) u_ad (
        .clk(clk), .rst(rst), .clr(clr), .wr(wr[SEL_AD]), .data(in_data),
        .idx(i_q), .full(full[SEL_AD]), .bit_o(bits[SEL_AD])
    );
    ascon_field_buf #(.LEN(text_l), .W(W), .IW(IW)) u_text (
        .clk(clk), .rst(rst), .clr(clr), .wr(wr[SEL_TEXT]), .data(in_data),
        .idx(i_q), .full(full[SEL_TEXT]), .bit_o(bits[SEL_TEXT])
    );
    ascon_field_buf #(.LEN(TAG_LEN), .W(W), .IW(IW)) u_tag (
        .clk(clk), .rst(rst), .clr(clr), .wr(wr[SEL_TAG]), .data(in_data),
        .idx(i_q), .full(full[SEL_TAG]), .bit_o(bits[SEL_TAG])
    );

    // Illegal selects 5-7 behave like permanently full fields.
    assign full_ext = {3'b111, full};

    assign in_ready = (state_q == ST_IDLE);
    assign busy     = (state_q != ST_IDLE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q         <= ST_IDLE;
            i_q             <= '0;
            sc_q            <= '0;
            dec_q           <= 1'b0;
            key_SO          <= 1'b0;
            nonce_SO        <= 1'b0;
            associated_SO   <= 1'b0;
            plaintext_SO    <= 1'b0;
            tag_SO          <= 1'b0;
            encryption_s_SO <= 1'b0;
            decryption_s_SO <= 1'b0;
            done            <= 1'b0;
            go_err          <= 1'b0;
            in_err          <= 1'b0;
        end else begin
            state_q         <= state_d;
            i_q             <= i_d;
            sc_q            <= sc_d;
            dec_q           <= dec_d;
            key_SO          <= key_d;
            nonce_SO        <= nonce_d;
            associated_SO   <= ad_d;
            plaintext_SO    <= pt_d;
            tag_SO          <= tag_d;
            encryption_s_SO <= enc_s_d;
            decryption_s_SO <= dec_s_d;
            done            <= done_d;
            go_err          <= go_err_d;
            in_err          <= in_err_d;
        end
    end

    // Outputs are decoded from the current state and registered, so each
    // state's effect appears one cycle later: bit i shows after SHIFT
    // cycle i, and the start line after each of the START_CYC START cycles.
    always_comb begin
        state_d  = state_q;
        i_d      = i_q;
        sc_d     = sc_q;
        dec_d    = dec_q;
        wr       = '0;
        clr      = 1'b0;
        key_d    = 1'b0;
        nonce_d  = 1'b0;
        ad_d     = 1'b0;
        pt_d     = 1'b0;
        tag_d    = 1'b0;
        enc_s_d  = 1'b0;
        dec_s_d  = 1'b0;
        done_d   = 1'b0;
        go_err_d = 1'b0;
        in_err_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    if (full_ext[in_sel]) in_err_d = 1'b1;
                    else                  wr = 5'b00001 << in_sel;
                end
                // Full flags here are the pre-write values of this cycle.
                if (go_enc || go_dec) begin
                    if (go_enc && go_dec) begin
                        go_err_d = 1'b1;
                    end else if (&full[SEL_TEXT:SEL_KEY] && (go_enc || full[SEL_TAG])) begin
                        state_d = ST_SHIFT;
                        i_d     = '0;
                        dec_d   = go_dec;
                    end else begin
                        go_err_d = 1'b1;
                    end
                end
            end
            ST_SHIFT: begin
                key_d   = bits[SEL_KEY];
                nonce_d = bits[SEL_NONCE];
                ad_d    = bits[SEL_AD];
                pt_d    = bits[SEL_TEXT];
                tag_d   = dec_q & bits[SEL_TAG];
                if (i_q == IW'(MAX - 1)) begin
                    state_d = ST_START;
                    sc_d    = '0;
                end else begin
                    i_d = i_q + IW'(1);
                end
            end
            ST_START: begin
                enc_s_d = ~dec_q;
                dec_s_d = dec_q;
                if (sc_q == SW'(START_CYC - 1)) state_d = ST_WAIT_DONE;
                else                            sc_d = sc_q + SW'(1);
            end
            ST_WAIT_DONE: begin
                if (done_i) begin
                    done_d  = 1'b1;
                    clr     = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ascon_serial_loader.sv
// Scoreboard bench for ascon_serial_loader. Stimulus pushes the expected
// output vector for every cycle in which the DUT should present something
// (busy, a status pulse, or an explicit probe); the monitor pops and
// compares on each such cycle.
module tb_ascon_serial_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [2:0] in_sel;
    logic       go_enc, go_dec, done_i;
    logic       key_SO, nonce_SO, associated_SO, plaintext_SO, tag_SO;
    logic       encryption_s_SO, decryption_s_SO;
    logic       busy, done, go_err, in_err;

    always #5 clk = ~clk;

    ascon_serial_loader dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sel(in_sel),
        .go_enc(go_enc), .go_dec(go_dec), .done_i(done_i),
        .key_SO(key_SO), .nonce_SO(nonce_SO), .associated_SO(associated_SO),
        .plaintext_SO(plaintext_SO), .tag_SO(tag_SO),
        .encryption_s_SO(encryption_s_SO), .decryption_s_SO(decryption_s_SO),
        .busy(busy), .done(done), .go_err(go_err), .in_err(in_err)
    );

    typedef struct {
        logic [11:0] vec;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    logic mon_en = 1'b0;
    logic probe  = 1'b0;

    logic [127:0] key_ref = 128'h000102030405060708090a0b0c0d0e0f;
    logic [127:0] pt_ref  = 128'h000102030405060708090a0b0c0d0e0f;
    logic [111:0] ad_ref  = 112'h000102030405060708090a0b0c0d;
    logic [127:0] tag_ref = 128'h526e4b15b4b3184a2fc1f7d160e4e972;

    // Order: key nonce ad pt tag enc_s dec_s busy done go_err in_err in_ready
    function automatic logic [11:0] mk(input logic kb, nb, ab, pb, tb, es, ds,
                                       input logic bz, dn, ge, ie, rd);
        return {kb, nb, ab, pb, tb, es, ds, bz, dn, ge, ie, rd};
    endfunction

    task automatic push(input logic [11:0] v, input string n);
        exp_t e;
        e.vec  = v;
        e.name = n;
        exp_q.push_back(e);
    endtask

    // Monitor
    logic [11:0] obs;
    exp_t        cur;
    always @(negedge clk) begin
        if (mon_en) begin
            obs = {key_SO, nonce_SO, associated_SO, plaintext_SO, tag_SO,
                   encryption_s_SO, decryption_s_SO, busy, done, go_err, in_err, in_ready};
            if (probe === 1'b1 || busy === 1'b1 || done === 1'b1 ||
                go_err === 1'b1 || in_err === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: got %b required none", obs);
                end else begin
                    cur = exp_q.pop_front();
                    if (obs !== cur.vec) begin
                        errors++;
                        $display("FAIL %s: got %b required %b", cur.name, obs, cur.vec);
                    end
                end
            end
        end
    end

    // All drivers act 1 time unit after a rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [2:0] s, input logic [7:0] d);
        in_valid = 1'b1;
        in_sel   = s;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic load_count(input logic [2:0] s, input int n);
        for (int j = 0; j < n; j++) write_word(s, 8'(j));
    endtask

    task automatic load_tag();
        for (int j = 0; j < 16; j++) write_word(3'd4, tag_ref[127-8*j -: 8]);
    endtask

    task automatic go_pulse(input logic e, input logic d);
        go_enc = e;
        go_dec = d;
        tick();
        go_enc = 1'b0;
        go_dec = 1'b0;
    endtask

    task automatic do_probe(input logic [11:0] v, input string n);
        push(v, n);
        probe = 1'b1;
        tick();
        probe = 1'b0;
    endtask

    // Expected: busy cycle right after go, then n serial bits.
    task automatic push_stream(input logic dec, input int n);
        logic kb, nb, ab, pb, tb;
        push(mk(0,0,0,0,0,0,0, 1,0,0,0,0), "shift_entry");
        for (int i = 0; i < n; i++) begin
            kb = key_ref[127-i];
            nb = key_ref[127-i];
            ab = (i < 112) ? ad_ref[111-i] : 1'b0;
            pb = pt_ref[127-i];
            tb = dec ? tag_ref[127-i] : 1'b0;
            push(mk(kb, nb, ab, pb, tb, 0, 0, 1,0,0,0,0),
                 $sformatf("%s_bit%0d", dec ? "dec" : "enc", i));
        end
    endtask

    task automatic run_full(input logic dec);
        push_stream(dec, 128);
        for (int i = 0; i < 5; i++)
            push(mk(0,0,0,0,0, ~dec, dec, 1,0,0,0,0), $sformatf("start%0d", i));
        for (int i = 0; i < 3; i++)
            push(mk(0,0,0,0,0,0,0, 1,0,0,0,0), $sformatf("wait%0d", i));
        push(mk(0,0,0,0,0,0,0, 0,1,0,0,1), "done_pulse");
        go_pulse(~dec, dec);
        repeat (136) @(posedge clk);
        #1;
        done_i = 1'b1;
        tick();
        done_i = 1'b0;
    endtask

    localparam logic [11:0] V_IDLE  = 12'b0000000_0000_1;
    localparam logic [11:0] V_GOERR = 12'b0000000_0010_1;
    localparam logic [11:0] V_INERR = 12'b0000000_0001_1;

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_data = '0; in_sel = '0;
        go_enc = 1'b0; go_dec = 1'b0; done_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst    = 1'b1;
        mon_en = 1'b1;
        do_probe(V_IDLE, "reset_state");

        load_count(3'd0, 16);
        load_count(3'd1, 16);
        load_count(3'd2, 14);
        load_count(3'd3, 16);

        push(V_GOERR, "go_dec_no_tag");
        go_pulse(1'b0, 1'b1);
        tick();

        push(V_INERR, "key_17th_word");
        push(V_INERR, "sel6_word");
        write_word(3'd0, 8'hFF);
        write_word(3'd6, 8'hAA);
        tick();

        push(V_GOERR, "go_both");
        go_pulse(1'b1, 1'b1);
        tick();

        run_full(1'b0);
        tick();

        load_count(3'd0, 16);
        load_count(3'd1, 16);
        load_count(3'd2, 14);
        load_count(3'd3, 16);
        load_tag();
        run_full(1'b1);
        tick();

        load_count(3'd0, 16);
        load_count(3'd1, 16);
        load_count(3'd2, 14);
        load_count(3'd3, 15);
        push(V_GOERR, "go_with_last_word");
        in_valid = 1'b1; in_sel = 3'd3; in_data = 8'h0F; go_enc = 1'b1;
        tick();
        in_valid = 1'b0; go_enc = 1'b0;

        push_stream(1'b0, 40);
        go_pulse(1'b1, 1'b0);
        repeat (40) @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        do_probe(V_IDLE, "after_mid_shift_reset");

        push(V_GOERR, "go_after_reset");
        go_pulse(1'b1, 1'b0);
        repeat (4) tick();

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_expected: got %0d pending required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        checks++;
        errors++;
        $display("FAIL timeout: got no finish required finish within 200000");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ascon_serial_loader.md
Name: ascon_serial_loader

Overview:
Upstream feeder for the ascon core. A host writes key, nonce, associated data, text and tag as W-bit words over a valid/ready port. The block buffers them, then streams every field MSB-first onto the core's bit-serial inputs in one shared MAX-cycle window. It then pulses the encryption or decryption start line and waits for the core's ready flag.

Parameters:
k, 128, key length in bits
A_l, 112, associated-data length in bits
text_l, 128, plaintext/ciphertext length in bits
W, 8, host word width; k, A_l, text_l and 128 must each be multiples of W
START_CYC, 5, cycles the start line is held high
MAX, max(k, A_l, text_l, 128) (derived), length of the serial window

Ports:
clk  in  1  single clock, rising edge
rst  in  1  reset, synchronous, active-low
in_valid  in  1  host word valid
in_ready  out  1  host word accepted when in_valid & in_ready
in_data  in  W  word, first word = most significant
in_sel  in  3  field: 0 key, 1 nonce, 2 AD, 3 text, 4 tag; 5-7 illegal
go_enc  in  1  request encryption
go_dec  in  1  request decryption
done_i  in  1  core encryption_r/decryption_r (OR of both)
key_SO  out  1  serial key bit to core key_SI
nonce_SO  out  1  serial nonce bit (128-bit field)
associated_SO  out  1  serial AD bit
plaintext_SO  out  1  serial text bit
tag_SO  out  1  serial tag bit (128-bit field)
encryption_s_SO  out  1  core encryption start
decryption_s_SO  out  1  core decryption start
busy  out  1  high in any state but IDLE
done  out  1  one-cycle pulse when done_i is seen
go_err  out  1  one-cycle pulse: go rejected
in_err  out  1  one-cycle pulse: word dropped

Behaviour:
- Reset (rst==0 at an edge): state IDLE. All outputs 0 except in_ready=1 from the next cycle. Buffers, word counters and full flags are cleared. Reset mid-SHIFT/START/WAIT aborts at once.
- FSM states: IDLE, SHIFT, START, WAIT_DONE.
- IDLE:
  - in_ready=1.
  - On an accepted word, the selected buffer shifts left by W, with in_data entering the LSBs. Its word counter increments, and the full flag sets when the count reaches len/W.
  - A word for a full field or for in_sel 5-7 is dropped and pulses in_err on the next cycle. Buffers are unchanged.
- go requests:
  - go_enc needs key, nonce, AD and text full. go_dec also needs tag full.
  - Full flags are sampled before any word accepted in the same cycle.
  - Satisfied: latch mode and go to SHIFT next cycle.
  - Unsatisfied, or go_enc & go_dec together: go_err pulse, stay IDLE.
- SHIFT:
  - in_ready=0. Counter i runs 0..MAX-1, one bit per cycle, all serial outputs registered.
  - On cycle i, key_SO=key[k-1-i] if i<k else 0. The same rule applies to each field with its own length.
  - tag_SO is driven 0 for encryption mode.
  - After the cycle with i=MAX-1, go to START. All serial outputs return to 0.
- START: the selected start line is high for exactly START_CYC cycles, then go to WAIT_DONE.
- WAIT_DONE:
  - Wait for done_i==1. Then pulse done for 1 cycle, clear word counters and full flags (buffer contents are don't-care) and return to IDLE.
  - done_i is ignored in all other states.
- Latency: from the go edge to the first serial bit is 1 cycle. The start line rises MAX+1 cycles after go.
- in_valid during a busy state is not accepted (in_ready=0) and is not an error.

Decomposition:
- Package ascon_pkg holds:
  - field-select constants (SEL_KEY..SEL_TAG)
  - FSM state enum
  - TAG_LEN=128, NONCE_LEN=128
  - MAX computation function
- One sub-module, ascon_field_buf (params LEN, W):
  - holds the shift buffer, word counter, full flag and bit-select output
  - instantiated five times.

Test Plan:
- Load key=nonce=000102..0F, AD=000102..0D (14 words), PT=000102..0F, then go_enc -> the serial streams match MSB-first for 128 cycles. associated_SO is 0 for cycles 112-127. encryption_s_SO is high for 5 cycles starting at cycle 129 after go.
- Same load plus tag=526e4b15b4b3184a2fc1f7d160e4e972, then go_dec -> tag_SO reproduces the tag and decryption_s_SO pulses. A done_i pulse -> done for 1 cycle, busy=0, in_ready=1.
- go_dec with tag not loaded -> go_err pulses, state stays IDLE, no serial activity.
- Write a 17th key word, then in_sel=6 -> in_err pulses twice and the key buffer is unchanged.
- go_enc and go_dec in the same cycle -> go_err. A word plus go_enc in the cycle that completes PT -> word taken, go_err; a go_enc on the next cycle succeeds.
- rst=0 at SHIFT cycle 40 -> all outputs 0 next cycle, full flags cleared. A following go_enc -> go_err.
